// File: rtl/raster_dispatch.sv
// Triangle FIFO and bit-serial frame scheduler for the raster unit.
// Optional watchdog enabled by defining RASTER_DISPATCH_TIMEOUT_EN.
module raster_dispatch #(
  parameter int FIFO_DEPTH     = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         TRI_VALID,
  output logic         TRI_READY,
  input  logic [143:0] TRI_DATA,
  output logic         R_START,
  output logic         R_V0X,
  output logic         R_V0Y,
  output logic         R_C0,
  output logic         R_V1X,
  output logic         R_V1Y,
  output logic         R_C1,
  output logic         R_V2X,
  output logic         R_V2Y,
  output logic         R_C2,
  input  logic         R_DONE,
  output logic         R_RST,
  output logic         BUSY,
  output logic [15:0]  TRI_COUNT,
  output logic         ERR
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DONE, GAP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [143:0]     mem_q [FIFO_DEPTH];
  logic [8:0][15:0] shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [15:0]      tri_count_q, tri_count_d;
  logic             start_q, start_d;
  logic             push, pop, full, timeout_hit;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign TRI_READY = !RST && !full;
  assign push      = TRI_VALID && TRI_READY;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    gap_d       = gap_q;
    tri_count_d = tri_count_q;
    start_d     = start_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = 4'd0;
          start_d   = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        for (int i = 0; i < 9; i++) shift_d[i] = {shift_q[i][14:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          state_d = WAIT_DONE;
          start_d = 1'b0;
          shift_d = '0;
        end
      end
      WAIT_DONE: begin
        // A real completion wins over a coincident watchdog expiry.
        if (R_DONE) begin
          tri_count_d = tri_count_q + 16'd1;
          gap_d       = GW'(GAP_CYCLES);
          state_d     = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else if (timeout_hit) begin
          gap_d   = GW'(GAP_CYCLES);
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q <= GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_q       <= '0;
      tri_count_q <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_q       <= gap_d;
      tri_count_q <= tri_count_d;
      start_q     <= start_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= TRI_DATA;
  end

`ifdef RASTER_DISPATCH_TIMEOUT_EN
  logic [20:0] to_q, to_d;
  logic        r_rst_q, r_rst_d, err_q, err_d;

  assign timeout_hit = (state_q == WAIT_DONE) && ((to_q + 21'd1) == 21'(TIMEOUT_CYCLES));

  always_comb begin
    to_d    = '0;
    r_rst_d = 1'b0;
    err_d   = err_q;
    if (state_q == WAIT_DONE && !R_DONE) begin
      to_d = to_q + 21'd1;
      if (timeout_hit) begin
        to_d    = '0;
        r_rst_d = 1'b1;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      to_q    <= '0;
      r_rst_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      to_q    <= to_d;
      r_rst_q <= r_rst_d;
      err_q   <= err_d;
    end
  end

  assign R_RST = r_rst_q;
  assign ERR   = err_q;
`else
  assign timeout_hit = 1'b0;
  assign R_RST       = 1'b0;
  assign ERR         = 1'b0;
`endif

  assign R_START   = start_q;
  assign R_V0X     = shift_q[8][15];
  assign R_V0Y     = shift_q[7][15];
  assign R_C0      = shift_q[6][15];
  assign R_V1X     = shift_q[5][15];
  assign R_V1Y     = shift_q[4][15];
  assign R_C1      = shift_q[3][15];
  assign R_V2X     = shift_q[2][15];
  assign R_V2Y     = shift_q[1][15];
  assign R_C2      = shift_q[0][15];
  assign BUSY      = (state_q != IDLE) || (count_q != '0);
  assign TRI_COUNT = tri_count_q;

endmodule

// File: tb/tb_raster_dispatch.sv
// Self-checking bench for raster_dispatch: timing-level reference model plus directed scenarios.
module tb_raster_dispatch;

   localparam int DEPTH = 2;
   localparam int GAP   = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic         TRI_VALID;
   logic         TRI_READY;
   logic [143:0] TRI_DATA;
   logic         R_START;
   logic         R_V0X, R_V0Y, R_C0, R_V1X, R_V1Y, R_C1, R_V2X, R_V2Y, R_C2;
   logic         R_DONE;
   logic         R_RST;
   logic         BUSY;
   logic [15:0]  TRI_COUNT;
   logic         ERR;

   raster_dispatch #(
      .FIFO_DEPTH(DEPTH),
      .GAP_CYCLES(GAP),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .CLK(CLK), .RST(RST), .TRI_VALID(TRI_VALID), .TRI_READY(TRI_READY),
      .TRI_DATA(TRI_DATA), .R_START(R_START),
      .R_V0X(R_V0X), .R_V0Y(R_V0Y), .R_C0(R_C0),
      .R_V1X(R_V1X), .R_V1Y(R_V1Y), .R_C1(R_C1),
      .R_V2X(R_V2X), .R_V2Y(R_V2Y), .R_C2(R_C2),
      .R_DONE(R_DONE), .R_RST(R_RST), .BUSY(BUSY),
      .TRI_COUNT(TRI_COUNT), .ERR(ERR)
   );

   // Free-running clock, 10 time units per period
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Single comparison point shared by the model process and the directed scenarios
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model state: queued triangles, the frame in flight and the edge it started on
   logic [143:0] mq[$];
   logic [143:0] cur;
   int           phase = 0;
   int           n = 0;
   int           frame_edge = 0;
   int           earliest = 0;
   logic [15:0]  m_count = 16'd0;
   bit           m_rdy;
   logic [8:0]   exp_lines;
   logic [8:0]   act_lines;

   // Model updates on each rising edge from the sampled inputs, then compares on the falling edge.
   // phase 0 = free, 1 = frame on the lines, 2 = awaiting completion.
   always begin
      @(posedge CLK);
      n++;
      if (RST) begin
         mq.delete();
         phase    = 0;
         earliest = 0;
         m_count  = 16'd0;
      end else begin
         m_rdy = (mq.size() < DEPTH);
         if (phase == 2 && R_DONE) begin
            m_count  = m_count + 16'd1;
            phase    = 0;
            earliest = n + GAP + 1;
         end
         if (phase == 1 && n == frame_edge + 16) phase = 2;
         if (phase == 0 && n >= earliest && mq.size() > 0) begin
            cur        = mq.pop_front();
            frame_edge = n;
            phase      = 1;
         end
         if (TRI_VALID && m_rdy) mq.push_back(TRI_DATA);
      end
      @(negedge CLK);
      exp_lines = '0;
      if (phase == 1)
         for (int j = 0; j < 9; j++) exp_lines[8-j] = cur[143 - 16*j - (n - frame_edge)];
      act_lines = {R_V0X, R_V0Y, R_C0, R_V1X, R_V1Y, R_C1, R_V2X, R_V2Y, R_C2};
      checkOutput("model_start", {31'd0, R_START}, {31'd0, phase == 1});
      checkOutput("model_lines", {23'd0, act_lines}, {23'd0, exp_lines});
      checkOutput("model_ready", {31'd0, TRI_READY}, {31'd0, !RST && (mq.size() < DEPTH)});
      checkOutput("model_busy", {31'd0, BUSY},
                  {31'd0, (phase != 0) || (mq.size() > 0) || (n < earliest - 1)});
      checkOutput("model_count", {16'd0, TRI_COUNT}, {16'd0, m_count});
      checkOutput("model_rrst_err", {30'd0, R_RST, ERR}, 32'd0);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present one triangle and hold it until an edge accepts it, bounded to 50 cycles
   task automatic applyStimulus(input logic [143:0] d);
      bit acc;
      TRI_VALID = 1'b1;
      TRI_DATA  = d;
      for (int t = 0; t <= 50; t++) begin
         @(posedge CLK);
         acc = TRI_READY;
         #1;
         if (acc) break;
         if (t == 50) checkOutput("push_timeout", 32'd0, 32'd1);
      end
      TRI_VALID = 1'b0;
   endtask

   task automatic pulseDone();
      R_DONE = 1'b1;
      tick();
      R_DONE = 1'b0;
   endtask

   localparam logic [143:0] T1 = {16'hA5C3, 16'h1357, 16'h2468, 16'h369C, 16'h48BF,
                                  16'h5AD1, 16'h6CE3, 16'h7F05, 16'h8117};
   localparam logic [143:0] T2 = {16'hFFFF, 16'h0001, 16'h8000, 16'h00FF, 16'hFF00,
                                  16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3};
   localparam logic [143:0] T3 = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                                  16'h6666, 16'h7777, 16'h8888, 16'h9999};
   localparam logic [143:0] T4 = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE,
                                  16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
   localparam logic [143:0] T5 = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1234,
                                  16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F1E};

   int          cnt;
   int          rise;
   logic [15:0] v0x, c2;

   // Directed scenarios with hand-derived timing and data expectations
   initial begin
      RST       = 1'b1;
      TRI_VALID = 1'b0;
      R_DONE    = 1'b0;
      TRI_DATA  = '0;
      repeat (3) tick();
      checkOutput("reset_ready", {31'd0, TRI_READY}, 32'd0);
      checkOutput("reset_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("reset_count", {16'd0, TRI_COUNT}, 32'd0);
      RST = 1'b0;
      #1;
      checkOutput("ready_out_of_reset", {31'd0, TRI_READY}, 32'd1);

      applyStimulus(T1);
      checkOutput("start_before_latency", {31'd0, R_START}, 32'd0);
      tick();
      checkOutput("start_latency", {31'd0, R_START}, 32'd1);
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick();
         cnt += int'(R_START);
         v0x[15-k] = R_V0X;
         c2[15-k]  = R_C2;
      end
      tick();
      checkOutput("start_after_frame", {31'd0, R_START}, 32'd0);
      checkOutput("start_width", cnt, 32'd16);
      checkOutput("v0x_serial", {16'd0, v0x}, 32'h0000A5C3);
      checkOutput("c2_serial", {16'd0, c2}, 32'h00008117);
      checkOutput("busy_wait_done", {31'd0, BUSY}, 32'd1);

      applyStimulus(T2);
      repeat (3) tick();
      pulseDone();
      checkOutput("count_after_done", {16'd0, TRI_COUNT}, 32'd1);
      rise = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (R_START) begin
            rise = k;
            break;
         end
      end
      checkOutput("gap_rise_delay", rise, 32'd5);

      cnt = 1;
      R_DONE = 1'b1;
      tick();
      R_DONE = 1'b0;
      for (int k = 0; k < 40 && R_START; k++) begin
         cnt++;
         tick();
      end
      checkOutput("width_with_done_in_shift", cnt, 32'd16);
      checkOutput("count_done_in_shift", {16'd0, TRI_COUNT}, 32'd1);
      pulseDone();
      checkOutput("count_second", {16'd0, TRI_COUNT}, 32'd2);
      repeat (6) tick();
      pulseDone();
      checkOutput("count_done_in_idle", {16'd0, TRI_COUNT}, 32'd2);
      checkOutput("busy_idle", {31'd0, BUSY}, 32'd0);

      applyStimulus(T3);
      applyStimulus(T4);
      applyStimulus(T5);
      checkOutput("ready_full", {31'd0, TRI_READY}, 32'd0);
      checkOutput("start_during_full", {31'd0, R_START}, 32'd1);

      repeat (6) tick();
      checkOutput("start_8th_cycle", {31'd0, R_START}, 32'd1);
      RST = 1'b1;
      tick();
      checkOutput("abort_start", {31'd0, R_START}, 32'd0);
      checkOutput("abort_lines", {23'd0, R_V0X, R_V0Y, R_C0, R_V1X, R_V1Y, R_C1, R_V2X, R_V2Y, R_C2}, 32'd0);
      checkOutput("abort_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("abort_ready", {31'd0, TRI_READY}, 32'd0);
      RST = 1'b0;
      #1;
      checkOutput("abort_ready_release", {31'd0, TRI_READY}, 32'd1);
      repeat (5) tick();
      checkOutput("flushed_no_start", {31'd0, R_START}, 32'd0);
      checkOutput("flushed_busy", {31'd0, BUSY}, 32'd0);

      applyStimulus(T4);
      repeat (17) tick();
      pulseDone();
      checkOutput("count_after_abort", {16'd0, TRI_COUNT}, 32'd1);
      repeat (8) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
